// File: rtl/uart_tx_pkg.sv
// Shared UART transmit types, frame limits and config helpers.
package uart_tx_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned UART_MIN_DATA_BITS = 5;
  localparam int unsigned UART_MAX_DATA_BITS = 8;

  typedef logic [UART_DATA_W-1:0] uart_data_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Out-of-range data bit counts fall back to a full byte.
  function automatic logic [3:0] sanitize_bits(input logic [3:0] bits);
    if (bits < 4'(UART_MIN_DATA_BITS) || bits > 4'(UART_MAX_DATA_BITS)) begin
      return 4'(UART_MAX_DATA_BITS);
    end
    return bits;
  endfunction

  // Mask keeping only the low `bits` data bits of a byte.
  function automatic uart_data_t data_mask(input logic [3:0] bits);
    uart_data_t ones;
    ones = '1;
    return uart_data_t'(ones >> (4'(UART_MAX_DATA_BITS) - bits));
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: reloads at every bit start and flags the last cycle of the bit.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_done
);

  logic [DIV_WIDTH-1:0] cnt;

  // Down-counter; div is already sanitised to be at least 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div - DIV_WIDTH'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_WIDTH'(1);
    end
  end

  assign bit_done = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 32,
  parameter int unsigned DATA_W    = UART_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [3:0]           data_bits,
  input  logic                 parity_en,
  input  logic                 odd_parity,
  input  logic                 two_stop,
  input  logic                 tx_valid,
  input  logic [DATA_W-1:0]    tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  uart_tx_state_t       state;
  logic [DIV_WIDTH-1:0] div_q;
  logic [3:0]           nbits_q;
  logic [3:0]           bit_idx;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 two_stop_q;
  logic                 stop_idx;
  uart_data_t           shreg;

  logic                 accept;
  logic                 step;
  logic                 bit_done;
  logic                 timer_load;
  logic [DIV_WIDTH-1:0] div_in;
  logic [DIV_WIDTH-1:0] timer_div;
  logic [3:0]           bits_in;
  uart_data_t           data_in;

  // Handshake and sanitised config seen on the accept cycle.
  assign tx_ready   = (state == IDLE);
  assign tx_busy    = !tx_ready;
  assign accept     = tx_valid && tx_ready;
  assign div_in     = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
  assign bits_in    = sanitize_bits(data_bits);
  assign data_in    = uart_data_t'(tx_data) & data_mask(bits_in);
  assign step       = bit_done && (state != IDLE);
  assign timer_load = accept || step;
  assign timer_div  = accept ? div_in : div_q;

  uart_tx_bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .div     (timer_div),
    .bit_done(bit_done)
  );

  // Frame sequencer with registered serial output and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      div_q      <= DIV_WIDTH'(1);
      nbits_q    <= 4'(UART_MAX_DATA_BITS);
      bit_idx    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= START;
            tx         <= 1'b0;
            div_q      <= div_in;
            nbits_q    <= bits_in;
            par_en_q   <= parity_en;
            par_bit_q  <= (^data_in) ^ odd_parity;
            two_stop_q <= two_stop;
            shreg      <= data_in;
          end
        end
        START: begin
          if (step) begin
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (step) begin
            if (bit_idx == nbits_q - 4'd1) begin
              if (par_en_q) begin
                state <= PARITY;
                tx    <= par_bit_q;
              end else begin
                state    <= STOP;
                tx       <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (step) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (step) begin
            if (stop_idx == two_stop_q) begin
              state   <= IDLE;
              tx_done <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table-driven frames plus back-to-back and reset sequences.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] baud_div;
  logic [3:0]  data_bits;
  logic        parity_en;
  logic        odd_parity;
  logic        two_stop;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;

  int tests  = 0;
  int failed = 0;
  int done_count = 0;

  uart_tx #(.DIV_WIDTH(32), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_div  (baud_div),
    .data_bits (data_bits),
    .parity_en (parity_en),
    .odd_parity(odd_parity),
    .two_stop  (two_stop),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_done === 1'b1) done_count <= done_count + 1;
  end

  // frame bit i is the i-th bit on the line; nbits/div_eff are hand-derived
  typedef struct packed {
    logic [31:0] div;
    logic [3:0]  bits;
    logic        par;
    logic        odd;
    logic        two;
    logic [7:0]  data;
    logic [7:0]  div_eff;
    logic [3:0]  nbits;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send one frame, scramble the config mid-frame, check every bit and the done pulse.
  task automatic run_vec(input vec_t v, input int idx);
    logic got;
    logic busy_ok;
    @(negedge clk);
    baud_div   = v.div;
    data_bits  = v.bits;
    parity_en  = v.par;
    odd_parity = v.odd;
    two_stop   = v.two;
    tx_data    = v.data;
    tx_valid   = 1'b1;
    @(negedge clk);
    tx_valid   = 1'b0;
    baud_div   = 32'd7;
    data_bits  = 4'd5;
    parity_en  = ~v.par;
    odd_parity = ~v.odd;
    two_stop   = ~v.two;
    tx_data    = ~v.data;
    busy_ok    = 1'b1;
    for (int b = 0; b < int'(v.nbits); b++) begin
      got = v.frame[b];
      for (int c = 0; c < int'(v.div_eff); c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (tx !== v.frame[b]) got = tx;
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0) busy_ok = 1'b0;
      end
      chk($sformatf("vec%0d bit%0d", idx, b), 32'(got), 32'(v.frame[b]));
    end
    chk($sformatf("vec%0d busy during frame", idx), 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk($sformatf("vec%0d done pulse", idx), 32'(tx_done), 32'd1);
    chk($sformatf("vec%0d ready at done", idx), 32'(tx_ready), 32'd1);
    chk($sformatf("vec%0d idle tx", idx), 32'(tx), 32'd1);
    @(negedge clk);
    chk($sformatf("vec%0d done one cycle", idx), 32'(tx_done), 32'd0);
  endtask

  // Bench receiver: called at the first cycle of a start bit, samples each bit's first cycle.
  task automatic rx_bits(input int div, input string name, output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      b[i] = tx;
    end
    repeat (div) @(negedge clk);
    chk({name, " stop"}, 32'(tx), 32'd1);
  endtask

  initial begin
    logic [7:0] b0;
    logic [7:0] b1;
    int         d0;

    vecs[0] = '{div: 32'd4, bits: 4'd8,  par: 1'b0, odd: 1'b0, two: 1'b0, data: 8'hA5,
                div_eff: 8'd4, nbits: 4'd10, frame: 12'h34A};
    vecs[1] = '{div: 32'd4, bits: 4'd8,  par: 1'b1, odd: 1'b0, two: 1'b0, data: 8'hA5,
                div_eff: 8'd4, nbits: 4'd11, frame: 12'h54A};
    vecs[2] = '{div: 32'd4, bits: 4'd8,  par: 1'b1, odd: 1'b1, two: 1'b0, data: 8'hA5,
                div_eff: 8'd4, nbits: 4'd11, frame: 12'h74A};
    vecs[3] = '{div: 32'd2, bits: 4'd5,  par: 1'b0, odd: 1'b0, two: 1'b1, data: 8'hFF,
                div_eff: 8'd2, nbits: 4'd8,  frame: 12'h0FE};
    vecs[4] = '{div: 32'd0, bits: 4'd12, par: 1'b0, odd: 1'b0, two: 1'b0, data: 8'h3C,
                div_eff: 8'd1, nbits: 4'd10, frame: 12'h278};
    vecs[5] = '{div: 32'd3, bits: 4'd6,  par: 1'b1, odd: 1'b1, two: 1'b0, data: 8'hE5,
                div_eff: 8'd3, nbits: 4'd9,  frame: 12'h14A};
    vecs[6] = '{div: 32'd1, bits: 4'd7,  par: 1'b1, odd: 1'b0, two: 1'b1, data: 8'h7F,
                div_eff: 8'd1, nbits: 4'd11, frame: 12'h7FE};

    rst        = 1'b1;
    baud_div   = 32'd4;
    data_bits  = 4'd8;
    parity_en  = 1'b0;
    odd_parity = 1'b0;
    two_stop   = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset ready", 32'(tx_ready), 32'd1);
    chk("reset busy", 32'(tx_busy), 32'd0);
    chk("reset done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Back-to-back frames with tx_valid held high
    @(negedge clk);
    baud_div  = 32'd2;
    data_bits = 4'd8;
    parity_en = 1'b0;
    two_stop  = 1'b0;
    tx_data   = 8'h01;
    tx_valid  = 1'b1;
    @(negedge clk);
    chk("b2b start1", 32'(tx), 32'd0);
    tx_data = 8'h80;
    rx_bits(2, "b2b frame1", b0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b done1", 32'(tx_done), 32'd1);
    chk("b2b ready at done1", 32'(tx_ready), 32'd1);
    chk("b2b idle gap", 32'(tx), 32'd1);
    @(negedge clk);
    chk("b2b start2 after done", 32'(tx), 32'd0);
    tx_valid = 1'b0;
    rx_bits(2, "b2b frame2", b1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b done2", 32'(tx_done), 32'd1);
    chk("b2b byte1", 32'(b0), 32'h01);
    chk("b2b byte2", 32'(b1), 32'h80);
    repeat (2) @(negedge clk);

    // Reset asserted during data bit 3 (cycles 17..20 after accept at div 4)
    baud_div  = 32'd4;
    data_bits = 4'd8;
    tx_data   = 8'h00;
    tx_valid  = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre-reset data bit3", 32'(tx), 32'd0);
    d0 = done_count;
    #1 rst = 1'b1;
    #1;
    chk("mid-frame reset tx", 32'(tx), 32'd1);
    chk("mid-frame reset ready", 32'(tx_ready), 32'd1);
    chk("mid-frame reset busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no done after reset", 32'(done_count - d0), 32'd0);
    chk("idle after reset", 32'(tx), 32'd1);
    run_vec(vecs[0], 7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
